// File: rtl/ext_sram_mux_if.sv
// ext_sram_mux_if: groups the core request port and the multiplexed SRAM bus.
//   master: core/board side (drives the request, din and sram_rdy)
//   slave : controller side (drives completion, dtr and all bus strobes)
//   core  : valid, rw, size, addri, dtw -> ready, busy, dtr
//   bus   : din, sram_rdy -> dout, ale0, ale1, oe, we, bhe, ble, isout
interface ext_sram_mux_if;
  logic        valid;
  logic        rw;
  logic [1:0]  size;
  logic [31:0] addri;
  logic [31:0] dtw;
  logic        ready;
  logic        busy;
  logic [31:0] dtr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        ale0;
  logic        ale1;
  logic        oe;
  logic        we;
  logic        bhe;
  logic        ble;
  logic        isout;
  logic        sram_rdy;

  modport master (
    output valid, rw, size, addri, dtw, din, sram_rdy,
    input  ready, busy, dtr, dout, ale0, ale1, oe, we, bhe, ble, isout
  );

  modport slave (
    input  valid, rw, size, addri, dtw, din, sram_rdy,
    output ready, busy, dtr, dout, ale0, ale1, oe, we, bhe, ble, isout
  );
endinterface

// File: rtl/ext_sram_mux.sv
// ext_sram_mux: external SRAM controller for a 16-bit multiplexed address/data
// bus. A byte/half/word request at any alignment is split into 1-3 halfword
// beats, each driven as address-low, address-high, strobe, recovery.
// Parameters: AW physical address width (18..32), WS extra strobe cycles (0..15).
// Ports: clk, reset (sync, active-high), bus (ext_sram_mux_if.slave).
// Optional feature macro: EXT_SRAM_RDY_EN -- when defined, the strobe phase is
// stretched while bus.sram_rdy is low after the wait count has run out.
//
// state | meaning
// IDLE  | waiting for valid; request latched on accept
// A0    | low halfword-address phase (ale0)
// A1    | high address phase (ale1), dout[15] flags an upper-lane-only beat
// S     | strobe phase, WS+1 cycles (plus sram_rdy stretch when enabled)
// R     | recovery; ready pulses here on the last beat
module ext_sram_mux #(
  parameter int AW = 32,
  parameter int WS = 1
) (
  input logic           clk,
  input logic           reset,
  ext_sram_mux_if.slave bus
);
  typedef enum logic [2:0] {IDLE, A0, A1, S, R} state_t;
  state_t state;

  logic          rw_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   dtw_q;
  logic [1:0]    beat;
  logic [1:0]    nbeats;
  logic [3:0]    wcnt;
  logic [31:0]   rdata;

  logic ready_r, busy_r, ale0_r, ale1_r, oe_r, we_r, bhe_r, ble_r, isout_r;
  logic [15:0] dout_r;
  logic [31:0] dtr_r;

  // Beat view: describes the beat whose outputs are registered at this edge.
  // In IDLE it looks at the live request, in R at the following beat.
  logic [AW-1:0] c_addr;
  logic [1:0]    c_size;
  logic [1:0]    c_beat;
  logic [3:0]    c_n, c_o, c_end, c_p0, c_p1, c_nb4;
  logic          c_en0, c_en1;
  logic [1:0]    c_i0, c_i1;
  logic [AW-2:0] c_hw;
  logic [31:0]   c_hw32;
  logic [15:0]   c_wdata;
  logic [31:0]   c_rmerge;
  logic          last_beat;
  logic          s_go;

  always_comb begin
    c_addr = addr_q;
    c_size = size_q;
    c_beat = beat;
    if (state == IDLE) begin
      c_addr = bus.addri[AW-1:0];
      c_size = bus.size;
      c_beat = 2'd0;
    end else if (state == R) begin
      c_beat = beat + 2'd1;
    end
    case (c_size)
      2'd0:    c_n = 4'd1;
      2'd1:    c_n = 4'd2;
      default: c_n = 4'd4;
    endcase
    c_o   = {3'b000, c_addr[0]};
    c_end = c_o + c_n;
    // byte positions carried on lane0/lane1 of this beat
    c_p0  = {1'b0, c_beat, 1'b0};
    c_p1  = c_p0 + 4'd1;
    c_en0 = (c_p0 >= c_o) && (c_p0 < c_end);
    c_en1 = (c_p1 >= c_o) && (c_p1 < c_end);
    // request byte index of each lane; only meaningful when the lane is used
    c_i0  = 2'(c_p0 - c_o);
    c_i1  = 2'(c_p1 - c_o);
    c_nb4 = (c_end + 4'd1) >> 1;
    // halfword address wraps silently modulo 2^(AW-1)
    c_hw   = c_addr[AW-1:1] + {{(AW-3){1'b0}}, c_beat};
    c_hw32 = {{(33-AW){1'b0}}, c_hw};
    c_wdata = 16'd0;
    if (c_en0) c_wdata[7:0]  = dtw_q[{c_i0, 3'b000} +: 8];
    if (c_en1) c_wdata[15:8] = dtw_q[{c_i1, 3'b000} +: 8];
    c_rmerge = rdata;
    if (c_en0) c_rmerge[{c_i0, 3'b000} +: 8] = bus.din[7:0];
    if (c_en1) c_rmerge[{c_i1, 3'b000} +: 8] = bus.din[15:8];
  end

  assign last_beat = (beat == nbeats - 2'd1);

`ifdef EXT_SRAM_RDY_EN
  assign s_go = (wcnt == 4'd0) && bus.sram_rdy;
`else
  assign s_go = (wcnt == 4'd0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      dtw_q   <= 32'd0;
      beat    <= 2'd0;
      nbeats  <= 2'd0;
      wcnt    <= 4'd0;
      rdata   <= 32'd0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      ale0_r  <= 1'b0;
      ale1_r  <= 1'b0;
      oe_r    <= 1'b0;
      we_r    <= 1'b0;
      bhe_r   <= 1'b0;
      ble_r   <= 1'b0;
      isout_r <= 1'b0;
      dout_r  <= 16'd0;
      dtr_r   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            rw_q    <= bus.rw;
            size_q  <= bus.size;
            addr_q  <= bus.addri[AW-1:0];
            dtw_q   <= bus.dtw;
            beat    <= 2'd0;
            nbeats  <= c_nb4[1:0];
            rdata   <= 32'd0;
            busy_r  <= 1'b1;
            ale0_r  <= 1'b1;
            isout_r <= 1'b1;
            dout_r  <= c_hw32[15:0];
            state   <= A0;
          end
        end
        A0: begin
          ale0_r <= 1'b0;
          ale1_r <= 1'b1;
          dout_r <= {~c_en0, c_hw32[30:16]};
          state  <= A1;
        end
        A1: begin
          ale1_r  <= 1'b0;
          oe_r    <= ~rw_q;
          we_r    <= rw_q;
          isout_r <= rw_q;
          bhe_r   <= c_en1;
          ble_r   <= c_en0;
          dout_r  <= rw_q ? c_wdata : 16'd0;
          wcnt    <= 4'(WS);
          state   <= S;
        end
        S: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else if (s_go) begin
            oe_r    <= 1'b0;
            we_r    <= 1'b0;
            bhe_r   <= 1'b0;
            ble_r   <= 1'b0;
            isout_r <= 1'b0;
            dout_r  <= 16'd0;
            if (!rw_q) begin
              rdata <= c_rmerge;
              // dtr only moves when a read completes
              if (last_beat) dtr_r <= c_rmerge;
            end
            ready_r <= last_beat;
            state   <= R;
          end
        end
        R: begin
          ready_r <= 1'b0;
          if (last_beat) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            beat    <= beat + 2'd1;
            ale0_r  <= 1'b1;
            isout_r <= 1'b1;
            dout_r  <= c_hw32[15:0];
            state   <= A0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.dtr   = dtr_r;
  assign bus.dout  = dout_r;
  assign bus.ale0  = ale0_r;
  assign bus.ale1  = ale1_r;
  assign bus.oe    = oe_r;
  assign bus.we    = we_r;
  assign bus.bhe   = bhe_r;
  assign bus.ble   = ble_r;
  assign bus.isout = isout_r;

  // address bits above AW, sram_rdy in the fixed-timing build and spare
  // arithmetic bits are intentionally not consumed
  logic unused_bits;
  assign unused_bits = ^{bus.addri, bus.sram_rdy, c_nb4[3:2], c_hw32[31]};
endmodule

// File: tb/tb_ext_sram_mux.sv
module tb_ext_sram_mux;
  localparam int AW = 24;
  localparam int WS = 1;
  localparam longint unsigned HWMASK = (64'd1 << (AW - 1)) - 64'd1;
  localparam longint unsigned AMASK  = (64'd1 << AW) - 64'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ext_sram_mux_if bus_if();

  ext_sram_mux #(.AW(AW), .WS(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] trace_q[$];
  logic [31:0] dtr_q[$];
  logic [31:0] mdl_dtr = 32'd0;
  logic [31:0] cur_dtr = 32'd0;
  int          stall_left = 0;
  logic [15:0] mem [int unsigned];

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(int unsigned hw);
    if (mem.exists(hw)) return mem[hw];
    return 16'(hw * 32'd40503) ^ 16'(hw >> 13) ^ 16'h3C5A;
  endfunction

  function automatic logic [23:0] mk(logic a0, logic a1, logic o, logic w,
                                     logic bh, logic bl, logic io, logic rd,
                                     logic [15:0] d);
    return {a0, a1, o, w, bh, bl, io, rd, d};
  endfunction

  // Reference model: expected per-cycle bus trace and completion data,
  // built from the byte-position rules; then drives the request for one edge.
  task automatic start_req(bit rw_i, logic [1:0] sz, logic [31:0] a,
                           logic [31:0] d, int stall);
    longint unsigned am, hw;
    int o, n, nb, extra, scyc;
    logic [1:0]  en [3];
    logic [15:0] wd [3];
    logic [15:0] word;
    logic [31:0] rexp;
    am = 64'(a) & AMASK;
    o  = int'(am % 2);
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    nb = (o + n + 1) / 2;
`ifdef EXT_SRAM_RDY_EN
    extra = stall;
`else
    extra = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      en[k] = 2'b00;
      wd[k] = 16'h0;
    end
    rexp = 32'd0;
    for (int i = 0; i < n; i++) begin
      int p, k, ln;
      p  = o + i;
      k  = p / 2;
      ln = p % 2;
      hw = ((am >> 1) + 64'(k)) & HWMASK;
      en[k][ln] = 1'b1;
      wd[k][8*ln +: 8] = a == a ? d[8*i +: 8] : 8'h0;
      word = mem_rd(32'(hw));
      rexp[8*i +: 8] = word[8*ln +: 8];
    end
    for (int k = 0; k < nb; k++) begin
      hw = ((am >> 1) + 64'(k)) & HWMASK;
      trace_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, hw[15:0]));
      trace_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, {~en[k][0], hw[30:16]}));
      scyc = WS + 1 + ((k == 0) ? extra : 0);
      repeat (scyc)
        trace_q.push_back(mk(0, 0, !rw_i, rw_i, en[k][1], en[k][0], rw_i, 0,
                             rw_i ? wd[k] : 16'h0));
      trace_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, (k == nb - 1), 16'h0));
    end
    if (!rw_i) mdl_dtr = rexp;
    dtr_q.push_back(mdl_dtr);
    stall_left = stall;
    bus_if.valid = 1'b1;
    bus_if.rw    = rw_i;
    bus_if.size  = sz;
    bus_if.addri = a;
    bus_if.dtw   = d;
    @(posedge clk); #1;
  endtask

  // Junk on the request port while busy must be ignored.
  task automatic wait_idle();
    int cyc = 0;
    while (bus_if.busy) begin
      bus_if.valid = 1'($urandom);
      bus_if.rw    = 1'($urandom);
      bus_if.size  = 2'($urandom);
      bus_if.addri = $urandom;
      bus_if.dtw   = $urandom;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 300) begin
        check("busy_timeout", 32'(bus_if.busy), 32'd0);
        break;
      end
    end
    bus_if.valid = 1'b0;
  endtask

  task automatic req(bit rw_i, logic [1:0] sz, logic [31:0] a, logic [31:0] d,
                     int stall);
    start_req(rw_i, sz, a, d, stall);
    wait_idle();
  endtask

  // SRAM/latch device: rebuilds the halfword address from the latch phases,
  // presents data only once the wait count is exhausted, optionally stalls.
  initial begin
    logic [15:0] lat_lo;
    logic [14:0] lat_hi;
    int s_cnt;
    lat_lo = 16'h0;
    lat_hi = 15'h0;
    s_cnt = 0;
    bus_if.din = 16'h0;
    bus_if.sram_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bus_if.ale0) begin
        lat_lo = bus_if.dout;
        s_cnt = 0;
      end
      if (bus_if.ale1) lat_hi = bus_if.dout[14:0];
      bus_if.sram_rdy = 1'b1;
      bus_if.din = 16'($urandom);
      if (bus_if.oe || bus_if.we) begin
        s_cnt++;
        if (s_cnt >= WS + 1) begin
          bus_if.din = mem_rd({1'b0, lat_hi, lat_lo});
          if (stall_left > 0) begin
            bus_if.sram_rdy = 1'b0;
            stall_left--;
          end
        end
      end
    end
  end

  // Monitor: every busy cycle consumes one expected bus vector; ready also
  // consumes one expected dtr; idle cycles must be quiet with dtr held.
  initial begin
    logic [23:0] got;
    forever begin
      @(negedge clk);
      if (reset) continue;
      got = {bus_if.ale0, bus_if.ale1, bus_if.oe, bus_if.we, bus_if.bhe,
             bus_if.ble, bus_if.isout, bus_if.ready, bus_if.dout};
      if (bus_if.busy) begin
        if (trace_q.size() == 0) check("trace_underrun", 32'(got), 32'hFFFFFFFF);
        else check("bus_cycle", 32'(got), 32'(trace_q.pop_front()));
        if (bus_if.ready) begin
          if (dtr_q.size() == 0) check("ready_unexpected", 32'(bus_if.ready), 32'd0);
          else begin
            cur_dtr = dtr_q.pop_front();
            check("dtr", bus_if.dtr, cur_dtr);
          end
        end
      end else begin
        check("idle_outputs", 32'(got), 32'd0);
        check("dtr_hold", bus_if.dtr, cur_dtr);
      end
    end
  end

  initial begin
    int cyc;
    logic [31:0] a;
    reset = 1'b1;
    bus_if.valid = 1'b0;
    bus_if.rw    = 1'b0;
    bus_if.size  = 2'd0;
    bus_if.addri = 32'h0;
    bus_if.dtw   = 32'h0;
    mem[32'h80]  = 16'h2211;
    mem[32'h81]  = 16'h4433;
    mem[32'h101] = 16'h5A00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    req(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0);        // aligned word read
    req(1'b1, 2'd2, 32'h0000_0101, 32'hAABBCCDD, 0); // misaligned word write
    req(1'b0, 2'd0, 32'h0000_0203, 32'h0, 0);        // odd byte read
    req(1'b0, 2'd1, 32'h00FF_FFFF, 32'h0, 0);        // wrap at top of memory
    req(1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0, 0);        // size 3, high bits ignored
    req(1'b1, 2'd1, 32'h0000_0010, 32'h0000BEEF, 0); // aligned half write

    // reset in S of beat 0
    start_req(1'b0, 2'd2, 32'h0000_0101, 32'h0, 0);
    cyc = 0;
    while (!bus_if.oe && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) check("reach_strobe", 32'(bus_if.oe), 32'd1);
    bus_if.valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    trace_q.delete();
    dtr_q.delete();
    mdl_dtr = 32'd0;
    cur_dtr = 32'd0;
    repeat (4) @(posedge clk);
    #1;
    req(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0);

    req(1'b0, 2'd2, 32'h0000_0301, 32'h0, 3);        // sram_rdy held low 3 cycles
    req(1'b1, 2'd2, 32'h0000_0400, 32'h12345678, 3);

    for (int t = 0; t < 80; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = a | 32'((64'd1 << AW) - 64'd2);
      req(1'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("trace_left", 32'(trace_q.size()), 32'd0);
    check("dtr_left", 32'(dtr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
